lsu_mem_stage: RTL and testbench
================================

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have a single clock `clk`, rising-edge; reset `rst` is asynchronous, active-high.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, async active-high reset
- in_valid, in, 1, execute-stage op present
- in_ready, out, 1, stage can accept op
- alu_result, in, 32, ALU output: effective address, or pass-through result
- store_data, in, 32, rs2 value for stores
- mem_op, in, 2, 00 none / 01 load / 10 store / 11 reserved (treated as none)
- funct3, in, 3, 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd, in, 5, destination register
- reg_write, in, 1, op writes rd
- dmem_req, out, 1, memory request
- dmem_we, out, 1, write enable
- dmem_addr, out, 32, word-aligned address ({addr[31:2],2'b00})
- dmem_wdata, out, 32, lane-shifted store data
- dmem_wstrb, out, 4, byte strobes
- dmem_ack, in, 1, request accepted/completed
- dmem_rdata, in, 32, read word, valid when dmem_ack
- wb_valid, out, 1, one-cycle writeback pulse
- wb_we, out, 1, register write enable
- wb_rd, out, 5, destination
- wb_data, out, 32, writeback value
- wb_misalign, out, 1, misaligned-access flag

Function
REQ-003 SHALL implement FSM IDLE, MEM, DONE; in_ready = 1 only in IDLE.
REQ-004 Accept = in_valid & in_ready; all inputs SHALL be latched at accept; later input changes have no effect.
REQ-005 Non-memory op accepted: SHALL go to DONE; next cycle wb_valid=1, wb_data=alu_result, wb_we=reg_write, wb_misalign=0; latency 1.
REQ-006 Misaligned memory op (H/HU with addr[0]=1, W with addr[1:0]!=0, SH with addr[0]=1, SW with addr[1:0]!=0): SHALL issue no dmem_req; DONE next cycle with wb_misalign=1, wb_we=0, wb_data=address.
REQ-007 Aligned memory op: SHALL enter MEM; dmem_req=1 from the cycle after accept until the cycle dmem_ack=1 inclusive, with dmem_we/addr/wdata/wstrb held stable throughout.
REQ-008 Store strobes: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111; loads: wstrb=0, we=0.
REQ-009 Store wdata SHALL be the byte/half replicated across lanes (SB: {4{d[7:0]}}, SH: {2{d[15:0]}}, SW: d).
REQ-010 On dmem_req & dmem_ack: SHALL capture dmem_rdata, select lane by addr[1:0], sign-extend (B,H) or zero-extend (BU,HU), go to DONE.
REQ-011 DONE SHALL last exactly one cycle with wb_valid=1, then return to IDLE; wb_valid is 0 in every other state.
REQ-012 Load wb_we = reg_write & (rd!=0); store wb_we = 0; wb_rd = latched rd.
REQ-013 No timeout: MEM SHALL wait indefinitely for dmem_ack.
REQ-014 Unlisted funct3 on a load/store SHALL be treated as W.
REQ-015 Minimum load/store latency accept-to-wb_valid is 2 cycles (ack in the first MEM cycle).

Reset
REQ-016 rst SHALL force IDLE immediately; outputs: dmem_req=0, dmem_we=0, dmem_wstrb=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_misalign=0, in_ready=1 after release.
REQ-017 Reset during MEM SHALL drop dmem_req in the same cycle, with no wb_valid for the aborted op; an ack arriving during reset is ignored.

Verification
REQ-018 Pass-through: mem_op=00, alu_result=0x1234_5678, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5, wb_we=1.
REQ-019 LB sign-extend: addr=0x103, rdata=0x80FF_0000, ack after 3 cycles -> dmem_addr=0x100 held for 3 cycles, wb_data=0xFFFF_FF80; the same access as LBU gives 0x0000_0080.
REQ-020 SH: addr=0x202, store_data=0xDEAD_BEEF, immediate ack -> dmem_wstrb=4'b1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, wb_we=0; wb_valid 2 cycles after accept.
REQ-021 Misaligned LW at 0x0000_0006 -> no dmem_req at any cycle, wb_misalign=1, wb_data=0x6, wb_we=0.
REQ-022 Back-to-back: in_valid held high with two ops -> in_ready=0 from accept until the cycle after DONE; the second op is accepted only then, with no lost or duplicated wb_valid.
REQ-023 rst asserted in the 2nd MEM cycle with dmem_ack=0 -> dmem_req=0 in that same cycle, no wb_valid; after release, in_ready=1 and a new LW completes normally.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Execute-side op, data-memory port and writeback bundle for the LSU memory stage.
// The master side is the surrounding pipeline and memory; the slave side is the stage itself.
interface lsu_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [1:0]  mem_op;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_misalign;

  modport master (
    output in_valid, alu_result, store_data, mem_op, funct3, rd, reg_write,
    output dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_misalign
  );

  modport slave (
    input  in_valid, alu_result, store_data, mem_op, funct3, rd, reg_write,
    input  dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output wb_valid, wb_we, wb_rd, wb_data, wb_misalign
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: one op in flight; wb 1 cycle after accept (non-mem/misaligned) or 1 cycle after dmem_ack.
// Backpressure: in_ready only in IDLE; MEM holds the request until dmem_ack with no timeout.
module lsu_mem_stage (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  typedef struct packed {
    logic [1:0] size;   // 0 byte, 1 half, 2 word
    logic       uns;
    logic [1:0] lane;
  } ld_t;

  state_t      state, state_nxt;
  ld_t         ld_q;
  logic        accept, is_load, is_store, is_mem, misalign, mem_go, uns_in;
  logic [1:0]  size_in;
  logic [3:0]  strb_in;
  logic [31:0] wdata_in, rshift, load_ext;
  logic        dmem_we_q, wb_we_q, wb_mis_q;
  logic [3:0]  dmem_wstrb_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q, wb_data_q;
  logic [4:0]  wb_rd_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign is_load  = (bus.mem_op == 2'b01);
  assign is_store = (bus.mem_op == 2'b10);
  assign is_mem   = is_load | is_store;
  assign uns_in   = (bus.funct3 == 3'b100) | (bus.funct3 == 3'b101);

  always_comb begin
    size_in  = 2'd2;
    strb_in  = 4'b1111;
    wdata_in = bus.store_data;
    case (bus.funct3)
      3'b000, 3'b100: size_in = 2'd0;
      3'b001, 3'b101: size_in = 2'd1;
      default:        size_in = 2'd2;
    endcase
    case (size_in)
      2'd0: begin
        strb_in  = 4'b0001 << bus.alu_result[1:0];
        wdata_in = {4{bus.store_data[7:0]}};
      end
      2'd1: begin
        strb_in  = 4'b0011 << bus.alu_result[1:0];
        wdata_in = {2{bus.store_data[15:0]}};
      end
      default: begin
        strb_in  = 4'b1111;
        wdata_in = bus.store_data;
      end
    endcase
  end

  assign misalign = is_mem &
                    (((size_in == 2'd1) & bus.alu_result[0]) |
                     ((size_in == 2'd2) & (bus.alu_result[1:0] != 2'b00)));
  assign mem_go   = is_mem & ~misalign;

  // Lane select of the returned word, then sign/zero extension.
  assign rshift = bus.dmem_rdata >> {ld_q.lane, 3'b000};
  always_comb begin
    load_ext = bus.dmem_rdata;
    case (ld_q.size)
      2'd0:    load_ext = ld_q.uns ? {24'b0, rshift[7:0]}  : {{24{rshift[7]}},  rshift[7:0]};
      2'd1:    load_ext = ld_q.uns ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: load_ext = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = mem_go ? MEM : DONE;
      MEM:     if (bus.dmem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q         <= '0;
      dmem_we_q    <= 1'b0;
      dmem_wstrb_q <= 4'b0;
      dmem_addr_q  <= 32'b0;
      dmem_wdata_q <= 32'b0;
      wb_we_q      <= 1'b0;
      wb_mis_q     <= 1'b0;
      wb_rd_q      <= 5'b0;
      wb_data_q    <= 32'b0;
    end else if (accept) begin
      ld_q         <= '{size: size_in, uns: uns_in, lane: bus.alu_result[1:0]};
      dmem_we_q    <= mem_go & is_store;
      dmem_wstrb_q <= (mem_go & is_store) ? strb_in : 4'b0;
      dmem_addr_q  <= mem_go ? {bus.alu_result[31:2], 2'b00} : 32'b0;
      dmem_wdata_q <= (mem_go & is_store) ? wdata_in : 32'b0;
      // Misaligned ops report the faulting address through wb_data.
      wb_data_q    <= bus.alu_result;
      wb_we_q      <= is_mem ? (is_load & ~misalign & bus.reg_write & (bus.rd != 5'd0))
                             : bus.reg_write;
      wb_mis_q     <= misalign;
      wb_rd_q      <= bus.rd;
    end else if ((state == MEM) && bus.dmem_ack && !dmem_we_q) begin
      wb_data_q    <= load_ext;
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.dmem_req    = (state == MEM);
  assign bus.dmem_we     = dmem_we_q & bus.dmem_req;
  assign bus.dmem_wstrb  = dmem_wstrb_q & {4{bus.dmem_req}};
  assign bus.dmem_addr   = dmem_addr_q;
  assign bus.dmem_wdata  = dmem_wdata_q;
  assign bus.wb_valid    = (state == DONE);
  assign bus.wb_we       = wb_we_q & bus.wb_valid;
  assign bus.wb_misalign = wb_mis_q & bus.wb_valid;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed-vector bench for lsu_mem_stage: stimulus pushes expected writebacks and memory requests,
// independent monitor/responder processes pop and compare.
module tb_lsu_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_stage_if bus ();
  lsu_mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        we;
    logic        mis;
    logic        chk_data;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] cyc;
  } wb_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] delay;
  } mem_exp_t;

  wb_exp_t  wq[$];
  mem_exp_t mq[$];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int mcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic wb_exp_t mk_wb(input logic we, input logic mis, input logic [4:0] rd,
                                    input logic [31:0] data, input logic chk_data);
    wb_exp_t w;
    w.we = we; w.mis = mis; w.rd = rd; w.data = data; w.chk_data = chk_data; w.cyc = 0;
    return w;
  endfunction

  function automatic mem_exp_t mk_mem(input logic [31:0] addr, input logic we, input logic [3:0] wstrb,
                                      input logic [31:0] wdata, input logic [31:0] rdata,
                                      input logic [31:0] delay);
    mem_exp_t m;
    m.addr = addr; m.we = we; m.wstrb = wstrb; m.wdata = wdata; m.rdata = rdata; m.delay = delay;
    return m;
  endfunction

  // lat: cycles from accept to wb_valid; exp_wait: expected busy negedges before acceptance (-1 = unchecked)
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                       input bit want_wb, input wb_exp_t w, input int lat,
                       input bit want_mem, input mem_exp_t m, input int exp_wait, input bit keep);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.mem_op = op; bus.funct3 = f3; bus.alu_result = a;
    bus.store_data = sd; bus.rd = rd; bus.reg_write = rw;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1 within 50", waited);
      bus.in_valid = 1'b0;
      return;
    end
    if (exp_wait >= 0) chk("in_ready_busy_cycles", waited, exp_wait);
    @(posedge clk);
    #1;
    if (want_wb) begin
      w.cyc = cyc + lat - 1;
      wq.push_back(w);
    end
    if (want_mem) mq.push_back(m);
    if (!keep) begin
      // Scramble inputs after accept; the latched op must be unaffected.
      bus.in_valid = 1'b0; bus.alu_result = 32'hFFFF_FFFF; bus.store_data = 32'hFFFF_FFFF;
      bus.mem_op = 2'b10; bus.funct3 = 3'b000; bus.rd = 5'h1f; bus.reg_write = 1'b1;
    end
  endtask

  // Writeback monitor.
  always @(negedge clk) begin
    wb_exp_t w;
    if (!rst && bus.wb_valid) begin
      if (wq.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_wb: wb_valid=1 rd=%0d data=0x%08h, required no writeback", bus.wb_rd, bus.wb_data);
      end else begin
        w = wq.pop_front();
        chk("wb_cycle", cyc, w.cyc);
        chk("wb_rd", {27'b0, bus.wb_rd}, {27'b0, w.rd});
        chk("wb_we", {31'b0, bus.wb_we}, {31'b0, w.we});
        chk("wb_misalign", {31'b0, bus.wb_misalign}, {31'b0, w.mis});
        if (w.chk_data) chk("wb_data", bus.wb_data, w.data);
      end
    end
  end

  // Data-memory responder and request checker.
  always @(negedge clk) begin
    mem_exp_t m;
    if (rst) begin
      bus.dmem_ack = 1'b0;
      mcnt = 0;
    end else if (bus.dmem_ack) begin
      bus.dmem_ack = 1'b0;
      mcnt = 0;
      if (mq.size() != 0) mq.delete(0);
    end else if (bus.dmem_req) begin
      if (mq.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_dmem_req: dmem_req=1 addr=0x%08h, required 0", bus.dmem_addr);
      end else begin
        m = mq[0];
        chk("dmem_addr", bus.dmem_addr, m.addr);
        chk("dmem_we", {31'b0, bus.dmem_we}, {31'b0, m.we});
        chk("dmem_wstrb", {28'b0, bus.dmem_wstrb}, {28'b0, m.wstrb});
        if (m.we) chk("dmem_wdata", bus.dmem_wdata, m.wdata);
        mcnt++;
        if (mcnt >= int'(m.delay)) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = m.rdata;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  mem_exp_t no_mem;
  wb_exp_t  no_wb;

  initial begin
    int t;
    bus.in_valid = 1'b0; bus.alu_result = '0; bus.store_data = '0; bus.mem_op = '0;
    bus.funct3 = '0; bus.rd = '0; bus.reg_write = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    no_mem = mk_mem(0, 0, 0, 0, 0, 1);
    no_wb  = mk_wb(0, 0, 0, 0, 0);
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'b0, bus.dmem_we}, 32'd0);
    chk("rst_dmem_wstrb", {28'b0, bus.dmem_wstrb}, 32'd0);
    chk("rst_dmem_addr", bus.dmem_addr, 32'd0);
    chk("rst_dmem_wdata", bus.dmem_wdata, 32'd0);
    chk("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    chk("rst_wb_we", {31'b0, bus.wb_we}, 32'd0);
    chk("rst_wb_rd", {27'b0, bus.wb_rd}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_misalign", {31'b0, bus.wb_misalign}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // op, f3, addr, store_data, rd, rw, want_wb, wb, lat, want_mem, mem, exp_wait, keep
    issue(2'b00, 3'b010, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 1, mk_wb(1, 0, 5, 32'h1234_5678, 1), 1, 0, no_mem, -1, 0);
    issue(2'b01, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1, mk_wb(1, 0, 7, 32'hFFFF_FF80, 1), 4,
          1, mk_mem(32'h100, 0, 4'b0000, 0, 32'h80FF_0000, 3), -1, 0);
    issue(2'b01, 3'b100, 32'h0000_0103, 32'h0, 5'd8, 1'b1, 1, mk_wb(1, 0, 8, 32'h0000_0080, 1), 4,
          1, mk_mem(32'h100, 0, 4'b0000, 0, 32'h80FF_0000, 3), -1, 0);
    issue(2'b10, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd9, 1'b1, 1, mk_wb(0, 0, 9, 0, 0), 2,
          1, mk_mem(32'h200, 1, 4'b1100, 32'hBEEF_BEEF, 0, 1), -1, 0);
    issue(2'b01, 3'b010, 32'h0000_0006, 32'h0, 5'd10, 1'b1, 1, mk_wb(0, 1, 10, 32'h6, 1), 1, 0, no_mem, -1, 0);
    issue(2'b01, 3'b001, 32'h0000_0002, 32'h0, 5'd11, 1'b1, 1, mk_wb(1, 0, 11, 32'hFFFF_8001, 1), 3,
          1, mk_mem(32'h0, 0, 4'b0000, 0, 32'h8001_1234, 2), -1, 0);
    issue(2'b01, 3'b101, 32'h0000_0000, 32'h0, 5'd12, 1'b1, 1, mk_wb(1, 0, 12, 32'h0000_F234, 1), 2,
          1, mk_mem(32'h0, 0, 4'b0000, 0, 32'h8001_F234, 1), -1, 0);
    issue(2'b01, 3'b010, 32'h0000_0010, 32'h0, 5'd0, 1'b1, 1, mk_wb(0, 0, 0, 32'hCAFE_BABE, 1), 2,
          1, mk_mem(32'h10, 0, 4'b0000, 0, 32'hCAFE_BABE, 1), -1, 0);
    issue(2'b10, 3'b000, 32'h0000_0301, 32'h1122_3344, 5'd1, 1'b1, 1, mk_wb(0, 0, 1, 0, 0), 3,
          1, mk_mem(32'h300, 1, 4'b0010, 32'h4444_4444, 0, 2), -1, 0);
    issue(2'b10, 3'b010, 32'h0000_0400, 32'hA5A5_5A5A, 5'd6, 1'b1, 1, mk_wb(0, 0, 6, 0, 0), 2,
          1, mk_mem(32'h400, 1, 4'b1111, 32'hA5A5_5A5A, 0, 1), -1, 0);
    issue(2'b10, 3'b001, 32'h0000_0205, 32'h1234_5678, 5'd2, 1'b1, 1, mk_wb(0, 1, 2, 32'h205, 1), 1, 0, no_mem, -1, 0);
    issue(2'b10, 3'b010, 32'h0000_0402, 32'h1234_5678, 5'd3, 1'b1, 1, mk_wb(0, 1, 3, 32'h402, 1), 1, 0, no_mem, -1, 0);
    issue(2'b01, 3'b011, 32'h0000_0021, 32'h0, 5'd4, 1'b1, 1, mk_wb(0, 1, 4, 32'h21, 1), 1, 0, no_mem, -1, 0);
    issue(2'b01, 3'b110, 32'h0000_0040, 32'h0, 5'd13, 1'b1, 1, mk_wb(1, 0, 13, 32'h8765_4321, 1), 2,
          1, mk_mem(32'h40, 0, 4'b0000, 0, 32'h8765_4321, 1), -1, 0);
    issue(2'b11, 3'b010, 32'h0000_0055, 32'h0, 5'd14, 1'b0, 1, mk_wb(0, 0, 14, 32'h55, 1), 1, 0, no_mem, -1, 0);

    // Back-to-back with in_valid held: second op waits through MEM, MEM, DONE.
    issue(2'b01, 3'b010, 32'h0000_0080, 32'h0, 5'd15, 1'b1, 1, mk_wb(1, 0, 15, 32'h1357_9BDF, 1), 3,
          1, mk_mem(32'h80, 0, 4'b0000, 0, 32'h1357_9BDF, 2), -1, 1);
    issue(2'b00, 3'b000, 32'h0000_ABCD, 32'h0, 5'd16, 1'b1, 1, mk_wb(1, 0, 16, 32'h0000_ABCD, 1), 1, 0, no_mem, 3, 0);

    // Reset in the second MEM cycle of a load that never gets acked.
    issue(2'b01, 3'b010, 32'h0000_0500, 32'h0, 5'd17, 1'b1, 0, no_wb, 1,
          1, mk_mem(32'h500, 0, 4'b0000, 0, 32'h0, 100), -1, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_mid_mem_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("reset_mid_mem_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    chk("reset_mid_mem_in_ready", {31'b0, bus.in_ready}, 32'd1);
    mq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    issue(2'b01, 3'b010, 32'h0000_0504, 32'h0, 5'd3, 1'b1, 1, mk_wb(1, 0, 3, 32'h0BAD_F00D, 1), 3,
          1, mk_mem(32'h504, 0, 4'b0000, 0, 32'h0BAD_F00D, 2), -1, 0);

    t = 0;
    while ((wq.size() != 0 || mq.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", wq.size() + mq.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
